// File: rtl/fifo_pkg.sv
// Shared constants and helpers for blocks that consume the 64-bit FIFO.
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DATA_W = 64;

  function automatic int beats_of(input int out_w);
    return FIFO_DATA_W / out_w;
  endfunction

  function automatic bit width_ok(input int out_w);
    return (out_w > 0) && (out_w <= FIFO_DATA_W) && ((FIFO_DATA_W % out_w) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_drain_serializer.sv
// Drains the 64-bit FIFO (one-cycle read latency) and serialises each word
// into OUT_W-bit beats on a valid/ready stream.
`default_nettype none

module fifo_drain_serializer
  import fifo_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [FIFO_DATA_W-1:0] fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [31:0]            word_count
);

  localparam int BEATS = beats_of(OUT_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (!width_ok(OUT_W)) begin : g_width_check
    $error("fifo_drain_serializer: OUT_W must divide %0d", FIFO_DATA_W);
  end

  logic                   staged;
  logic                   wvalid;
  logic [CNT_W-1:0]       cnt;
  logic [FIFO_DATA_W-1:0] wbuf;

  logic accept;
  logic done;
  logic load;
  logic rd_req;

  assign accept = wvalid && out_ready;
  assign done   = accept && (cnt == LAST_BEAT);
  assign load   = staged && (!wvalid || done);

  // A new read may overlap the load of the staged word: the FIFO updates
  // dout at the same edge wbuf captures the old value.
  assign rd_req     = !fifo_empty && !flush && (!staged || load);
  assign fifo_rd_en = rd_req && !rst;

  assign out_valid = wvalid;
  assign out_last  = wvalid && (cnt == LAST_BEAT);

  if (MSB_FIRST) begin : g_msb_first
    assign out_data = wbuf[FIFO_DATA_W-1 -: OUT_W];
  end else begin : g_lsb_first
    assign out_data = wbuf[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staged     <= 1'b0;
      wvalid     <= 1'b0;
      cnt        <= '0;
      wbuf       <= '0;
      word_count <= '0;
    end else begin
      if (done) begin
        word_count <= word_count + 32'd1;
      end

      if (flush) begin
        staged <= 1'b0;
        wvalid <= 1'b0;
        cnt    <= '0;
      end else begin
        if (rd_req) begin
          staged <= 1'b1;
        end else if (load) begin
          staged <= 1'b0;
        end

        if (load) begin
          wbuf   <= fifo_dout;
          wvalid <= 1'b1;
          cnt    <= '0;
        end else if (accept) begin
          if (cnt == LAST_BEAT) begin
            wvalid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (MSB_FIRST) begin
              wbuf <= wbuf << OUT_W;
            end else begin
              wbuf <= wbuf >> OUT_W;
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_serializer.sv
// Bench: two serializer configurations (16-bit LSB-first, 32-bit MSB-first)
// fed by behavioural FIFOs and checked against a beat-queue reference model.
`default_nettype none

module tb_fifo_drain_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ready;
  logic [63:0] fdout[2];
  logic        fempty[2];
  logic        rd[2];
  logic        ov[2];
  logic        ol[2];
  logic [31:0] wc[2];
  logic [15:0] od_a;
  logic [31:0] od_b;

  always #5 clk = ~clk;

  fifo_drain_serializer #(.OUT_W(16), .MSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_dout(fdout[0]), .fifo_empty(fempty[0]), .fifo_rd_en(rd[0]),
    .out_data(od_a), .out_valid(ov[0]), .out_ready(ready),
    .out_last(ol[0]), .word_count(wc[0])
  );

  fifo_drain_serializer #(.OUT_W(32), .MSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_dout(fdout[1]), .fifo_empty(fempty[1]), .fifo_rd_en(rd[1]),
    .out_data(od_b), .out_valid(ov[1]), .out_ready(ready),
    .out_last(ol[1]), .word_count(wc[1])
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] fq[2][$];        // FIFO contents not yet read
  logic [64:0] exp_q[2][$];     // {last, data} beats still owed by the DUT
  logic [63:0] acc_log[2][$];   // beats accepted since last clear
  logic [31:0] exp_wc[2];
  logic [63:0] nxt_dout[2];
  logic        nxt_empty[2];
  logic        stalled[2];
  logic [63:0] held[2];
  int          rd_cnt[2];
  int          vcycles[2];
  int          run[2];
  int          maxrun[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected beats of a word for instance i, from the slicing rule alone.
  task automatic add_beats(input int i, input logic [63:0] w);
    int          bw;
    int          n;
    int          sh;
    logic [63:0] mask;
    bw   = (i == 0) ? 16 : 32;
    n    = 64 / bw;
    mask = (64'h1 << bw) - 64'h1;
    for (int k = 0; k < n; k++) begin
      sh = (i == 1) ? (n - 1 - k) * bw : k * bw;
      exp_q[i].push_back({(k == n - 1), (w >> sh) & mask});
    end
  endtask

  function automatic bit idle();
    for (int i = 0; i < 2; i++) begin
      if (fq[i].size() != 0 || exp_q[i].size() != 0 || ov[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: observe at the falling edge, update FIFO outputs at the
  // rising edge, return 1 time unit after it so callers drive inputs.
  task automatic cycle();
    logic [63:0] got;
    logic [64:0] e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? {48'h0, od_a} : {32'h0, od_b};
      if (rst) begin
        exp_q[i].delete();
        fq[i].delete();
        exp_wc[i]    = 32'd0;
        stalled[i]   = 1'b0;
        nxt_empty[i] = 1'b1;
        run[i]       = 0;
      end else begin
        check("word_count", wc[i], exp_wc[i]);
        check("rd_while_empty", rd[i] & fempty[i], 0);
        if (stalled[i]) check("stall_hold", got, held[i]);
        if (ov[i] && ready) begin
          check("beat_expected", (exp_q[i].size() > 0), 1);
          if (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            check("beat_data", got, e[63:0]);
            check("beat_last", ol[i], e[64]);
            if (e[64]) exp_wc[i] = exp_wc[i] + 32'd1;
          end
          acc_log[i].push_back(got);
        end
        stalled[i] = ov[i] && !ready && !flush;
        held[i]    = got;
        if (flush) exp_q[i].delete();
        if (rd[i] && fq[i].size() > 0) begin
          nxt_dout[i] = fq[i].pop_front();
          add_beats(i, nxt_dout[i]);
          rd_cnt[i]++;
        end
        nxt_empty[i] = (fq[i].size() == 0);
        if (ov[i]) begin
          vcycles[i]++;
          run[i]++;
          if (run[i] > maxrun[i]) maxrun[i] = run[i];
        end else begin
          run[i] = 0;
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      fdout[i]  <= nxt_dout[i];
      fempty[i] <= nxt_empty[i];
    end
    #1;
  endtask

  task automatic drain(input int budget);
    ready = 1'b1;
    flush = 1'b0;
    for (int c = 0; c < budget && !idle(); c++) cycle();
    check("drain_done", idle(), 1);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      acc_log[i].delete();
      rd_cnt[i]  = 0;
      vcycles[i] = 0;
      run[i]     = 0;
      maxrun[i]  = 0;
    end
  endtask

  initial begin
    logic [63:0] w;
    logic [31:0] wc_snap;
    rst = 1'b1; flush = 1'b0; ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fdout[i]    <= 64'h0;
      fempty[i]   <= 1'b1;
      nxt_dout[i] = 64'h0;
      nxt_empty[i] = 1'b1;
      exp_wc[i]   = 32'd0;
      stalled[i]  = 1'b0;
      held[i]     = 64'h0;
    end
    clear_stats();
    cycle(); cycle();

    // Reset state
    check("rst_valid_a", ov[0], 0);
    check("rst_valid_b", ov[1], 0);
    check("rst_last_a", ol[0], 0);
    check("rst_data_a", od_a, 0);
    check("rst_data_b", od_b, 0);
    check("rst_rd_a", rd[0], 0);
    check("rst_wc_b", wc[1], 0);
    rst = 1'b0;
    cycle();

    // Single word, both beat orders
    clear_stats();
    fq[0].push_back(64'h0011223344556677);
    fq[1].push_back(64'hDEADBEEFCAFEF00D);
    ready = 1'b1;
    drain(40);
    check("t1_nbeats", acc_log[0].size(), 4);
    check("t1_beat0", acc_log[0][0], 64'h6677);
    check("t1_beat1", acc_log[0][1], 64'h4455);
    check("t1_beat2", acc_log[0][2], 64'h2233);
    check("t1_beat3", acc_log[0][3], 64'h0011);
    check("t1_rd_pulses", rd_cnt[0], 1);
    check("t1_wc", wc[0], 1);
    check("t4_beat0", acc_log[1][0], 64'hDEADBEEF);
    check("t4_beat1", acc_log[1][1], 64'hCAFEF00D);
    check("t4_maxrun", maxrun[0], 4);

    // Three words back to back: gapless
    clear_stats();
    for (int k = 0; k < 3; k++) begin
      fq[0].push_back({$urandom, $urandom});
      fq[1].push_back({$urandom, $urandom});
    end
    drain(60);
    check("t2_gapless_a", maxrun[0], 12);
    check("t2_vcycles_a", vcycles[0], 12);
    check("t2_gapless_b", maxrun[1], 6);
    check("t2_rd_pulses", rd_cnt[0], 3);
    check("t2_wc", wc[0], 4);

    // Backpressure 1,0,0,1,...
    clear_stats();
    for (int k = 0; k < 2; k++) begin
      fq[0].push_back({$urandom, $urandom});
      fq[1].push_back({$urandom, $urandom});
    end
    for (int c = 0; c < 40; c++) begin
      ready = ((c % 3) == 0);
      cycle();
    end
    drain(60);
    check("t3_rd_pulses", rd_cnt[0], 2);
    check("t3_nbeats", acc_log[0].size(), 8);

    // Flush on beat 2 with a second word staged
    clear_stats();
    w = {$urandom, $urandom};
    fq[0].push_back({$urandom, $urandom});
    fq[0].push_back({$urandom, $urandom});
    fq[0].push_back(w);
    ready = 1'b1;
    for (int c = 0; c < 30 && acc_log[0].size() < 2; c++) cycle();
    check("t5_reach_beat2", acc_log[0].size(), 2);
    wc_snap = exp_wc[0];
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t5_valid_after_flush", ov[0], 0);
    acc_log[0].delete();
    drain(40);
    check("t5_next_beat0", acc_log[0][0], {48'h0, w[15:0]});
    check("t5_nbeats", acc_log[0].size(), 4);
    check("t5_wc", wc[0], wc_snap + 32'd1);

    // Asynchronous reset mid-word
    clear_stats();
    fq[0].push_back({$urandom, $urandom});
    fq[0].push_back({$urandom, $urandom});
    fq[1].push_back({$urandom, $urandom});
    ready = 1'b1;
    for (int c = 0; c < 30 && acc_log[0].size() < 1; c++) cycle();
    #3 rst = 1'b1;
    #1;
    check("t6_valid_a", ov[0], 0);
    check("t6_valid_b", ov[1], 0);
    check("t6_rd_a", rd[0], 0);
    check("t6_wc_a", wc[0], 0);
    check("t6_wc_b", wc[1], 0);
    cycle(); cycle();
    rst = 1'b0;
    fq[0].push_back({$urandom, $urandom});
    drain(40);
    check("t6_wc_after", wc[0], 1);

    // Random traffic with occasional flushes
    clear_stats();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) fq[$urandom_range(0, 1)].push_back({$urandom, $urandom});
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      cycle();
    end
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Downstream consumer of the 64-bit synchronous FIFO.
- Drives the FIFO's read enable and absorbs its one-cycle registered read latency.
- Splits each 64-bit word into OUT_W-bit beats on a valid/ready output stream.
- Sustains gapless output while the FIFO holds data; presents no combinational path from FIFO outputs to out_data/out_valid.

Parameters:
OUT_W, 16, output beat width; must divide 64 (8, 16, 32 or 64); BEATS = 64/OUT_W
MSB_FIRST, 0, 0 = emit bits [OUT_W-1:0] first; 1 = emit bits [63:64-OUT_W] first

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous discard of all buffered data
fifo_dout  in  64  FIFO read data; valid the cycle after a successful read, held until the next read
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read enable
out_data  out  OUT_W  current beat
out_valid  out  1  beat valid
out_ready  in  1  sink accepts the beat when out_valid && out_ready
out_last  out  1  high on the final beat of each 64-bit word
word_count  out  32  count of fully emitted words, wraps modulo 2^32

Behaviour:
- Reset (async assert, sync release):
  - staged=0, wvalid=0, cnt=0, wbuf=0, word_count=0.
  - Outputs: out_valid=0, out_data=0, out_last=0, fifo_rd_en=0.
- State:
  - staged: fifo_dout holds a read but unconsumed word.
  - wvalid: wbuf holds a word being emitted.
  - cnt: beat index, 0..BEATS-1.
- Derived signals:
  - accept = out_valid && out_ready.
  - done = accept && cnt==BEATS-1.
  - load = staged && (!wvalid || done).
- Read issue:
  - fifo_rd_en = !fifo_empty && !flush && (!staged || load).
  - Combinational path from out_ready to fifo_rd_en is permitted; no other FIFO-facing combinational paths.
- Staged flag:
  - fifo_rd_en=1 → staged=1 next cycle.
  - load without a new read → staged=0.
  - Load and read in the same cycle: wbuf captures the old fifo_dout while the FIFO updates dout at the same edge; staged stays 1.
- Word load:
  - On load: wbuf<=fifo_dout, wvalid<=1, cnt<=0.
  - done without load: wvalid<=0.
- Beat emission:
  - On accept with cnt<BEATS-1: cnt<=cnt+1.
  - MSB_FIRST=0: wbuf shifts right by OUT_W. MSB_FIRST=1: wbuf shifts left by OUT_W.
  - out_data is the low slice (MSB_FIRST=0) or high slice (MSB_FIRST=1) of wbuf.
  - out_valid = wvalid. out_last = wvalid && cnt==BEATS-1.
  - OUT_W=64: BEATS=1; every beat is last.
- word_count increments on done.
- Stream rules:
  - out_data and out_valid change only after accept, load, flush or reset.
  - Holding out_ready=0 holds out_data stable indefinitely.
- Latency:
  - FIFO non-empty, block idle: fifo_rd_en at cycle N, staged at N+1, wbuf loaded at end of N+1, out_valid at N+2.
  - Steady state: one beat per cycle with no gap between words while the FIFO stays non-empty.
- Flush:
  - Next edge: staged=0, wvalid=0, cnt=0; fifo_rd_en held 0 during the flush cycle.
  - word_count not cleared.
  - Any beat accepted in the flush cycle is counted normally.
- FIFO empty: once the staged word is consumed, out_valid falls after the last beat; fifo_rd_en is never asserted while fifo_empty=1.
- Reset mid-word: the partial word is lost. The FIFO's own reset is synchronous; the system asserts both resets together for at least one clock.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DATA_W=64.
  - Function beats_of(out_w) returning 64/out_w.
  - Elaboration-time check that OUT_W divides FIFO_DATA_W.
- No sub-module: the read-latency tracker and shift register are small and tightly coupled; single module, ~150-200 lines.

Test Plan:
1. OUT_W=16, MSB_FIRST=0, FIFO holds 0x0011223344556677, out_ready=1 → fifo_rd_en for 1 cycle; beats 0x6677, 0x4455, 0x2233, 0x0011 on consecutive cycles; out_last on 4th; word_count=1.
2. Three words queued, out_ready=1 → 12 consecutive beats with no bubble; exactly 3 fifo_rd_en pulses; word_count=3; out_valid low after beat 12.
3. Backpressure: out_ready toggles 1,0,0,1,... → out_data held stable while stalled; no fifo_rd_en until the staged word is loaded; beat order unchanged.
4. MSB_FIRST=1, OUT_W=32, word 0xDEADBEEFCAFEF00D → beats 0xDEADBEEF then 0xCAFEF00D (last).
5. flush asserted on beat 2 of a word with a second word staged → next cycle out_valid=0; both words discarded; the next FIFO word emits from beat 0; word_count unchanged.
6. rst asserted asynchronously mid-word → out_valid, fifo_rd_en and word_count go 0 immediately without a clock edge; after release, normal drain resumes.
